// File: rtl/puf_challenge_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// puf_ctrl_pkg
// Shared definitions for the PUF challenge sequencer slice: the controller
// state encoding, challenge/response widths and the number of evaluation
// passes used when majority voting is compiled in.
// ---------------------------------------------------------------------------
package puf_ctrl_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        EVAL = 2'd2,
        RESP = 2'd3
    } seqState_t;

    // Challenge and response word widths of the parallel PUF array
    localparam int PUF_CW = 8;
    localparam int PUF_RW = 8;

    // Evaluations per request when majority voting is enabled
    localparam int PUF_VOTES = 3;

endpackage

// File: rtl/puf_challenge_sequencer_if.sv
// ---------------------------------------------------------------------------
// puf_challenge_sequencer_if
// Bundles the host request/response handshakes and the PUF array connection
// of the sequencer.
//   slave  : the sequencer side (consumes requests, drives the array).
//   master : the environment side (host plus PUF array).
// Signals:
//   req_valid/req_ready/req_challenge   challenge request handshake
//   rsp_valid/rsp_ready/rsp_response    response handshake and data
//   rsp_timeout/rsp_unstable            response status flags
//   puf_enable/puf_challenge            drive to the array
//   puf_out/puf_all_done                return from the array
// ---------------------------------------------------------------------------
interface puf_challenge_sequencer_if;
    import puf_ctrl_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [PUF_CW-1:0] req_challenge;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [PUF_RW-1:0] rsp_response;
    logic              rsp_timeout;
    logic              rsp_unstable;
    logic              puf_enable;
    logic [PUF_CW-1:0] puf_challenge;
    logic [PUF_RW-1:0] puf_out;
    logic              puf_all_done;

    modport slave (
        input  req_valid, req_challenge, rsp_ready, puf_out, puf_all_done,
        output req_ready, rsp_valid, rsp_response, rsp_timeout, rsp_unstable,
               puf_enable, puf_challenge
    );

    modport master (
        output req_valid, req_challenge, rsp_ready, puf_out, puf_all_done,
        input  req_ready, rsp_valid, rsp_response, rsp_timeout, rsp_unstable,
               puf_enable, puf_challenge
    );

endinterface

// File: rtl/puf_majority3.sv
// ---------------------------------------------------------------------------
// puf_majority3
// Purely combinational bitwise 2-of-3 vote over three PUF response samples.
// Ports:
//   i_a, i_b, i_c  three response samples
//   o_majority     bitwise majority of the samples
//   o_disagree     high when any bit position is not identical in all three
// ---------------------------------------------------------------------------
module puf_majority3
    import puf_ctrl_pkg::*;
(
    input  logic [PUF_RW-1:0] i_a,
    input  logic [PUF_RW-1:0] i_b,
    input  logic [PUF_RW-1:0] i_c,
    output logic [PUF_RW-1:0] o_majority,
    output logic              o_disagree
);

    assign o_majority = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

    // A bit is unanimous only when a matches both b and c
    assign o_disagree = |((i_a ^ i_b) | (i_a ^ i_c));

endmodule

// File: rtl/puf_challenge_sequencer.sv
// ---------------------------------------------------------------------------
// puf_challenge_sequencer
// Accepts one challenge at a time, applies it to the parallel PUF array with
// enable low for a settle period, raises enable and waits (bounded by a cycle
// timeout) for all_done, then returns the captured response.
// Compile option PUF_MAJORITY_VOTE_EN: each challenge is evaluated three
// times and the response is the bitwise majority, with rsp_unstable flagging
// any disagreement. Without it a single pass is made and rsp_unstable is 0.
// Parameters:
//   SETTLE_CYCLES   cycles enable is held low with the challenge applied
//   TIMEOUT_CYCLES  maximum evaluation cycles waiting for all_done
// Ports:
//   clk             clock
//   computer_reset  asynchronous active-high reset
//   bus             request/response handshakes and PUF array connection
//   busy            high whenever the controller is not idle
// ---------------------------------------------------------------------------
module puf_challenge_sequencer
    import puf_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic                      clk,
    input  logic                      computer_reset,
    puf_challenge_sequencer_if.slave  bus,
    output logic                      busy
);

`ifdef PUF_MAJORITY_VOTE_EN
    localparam int NUM_PASSES = PUF_VOTES;
`else
    localparam int NUM_PASSES = 1;
`endif

    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [15:0] TO_LAST     = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  LAST_PASS   = 2'(NUM_PASSES - 1);

    seqState_t         r_state;
    seqState_t         w_nextState;
    logic [PUF_CW-1:0] r_challenge;
    logic [7:0]        r_settleCnt;
    logic [15:0]       r_toCnt;
    logic [1:0]        r_voteIdx;
    logic [PUF_RW-1:0] r_response;
    logic              r_timeout;
    logic              r_unstable;

    logic              w_settled;
    logic              w_toLast;
    logic              w_lastPass;
    logic              w_accept;
    logic              w_armToEval;
    logic              w_capture;
    logic              w_timeoutHit;
    logic [PUF_RW-1:0] w_result;
    logic              w_resultSplit;

    assign w_settled  = (r_settleCnt == SETTLE_LAST);
    assign w_toLast   = (r_toCnt == TO_LAST);
    assign w_lastPass = (r_voteIdx == LAST_PASS);

`ifdef PUF_MAJORITY_VOTE_EN
    logic [PUF_RW-1:0] r_sample0;
    logic [PUF_RW-1:0] r_sample1;

    // The third sample is voted straight from the array in its capture cycle
    always_ff @(posedge clk or posedge computer_reset) begin
        if (computer_reset) begin
            r_sample0 <= '0;
            r_sample1 <= '0;
        end else if (w_capture) begin
            if (r_voteIdx == 2'd0) r_sample0 <= bus.puf_out;
            if (r_voteIdx == 2'd1) r_sample1 <= bus.puf_out;
        end
    end

    puf_majority3 u_majority3 (
        .i_a        (r_sample0),
        .i_b        (r_sample1),
        .i_c        (bus.puf_out),
        .o_majority (w_result),
        .o_disagree (w_resultSplit)
    );
`else
    assign w_result      = bus.puf_out;
    assign w_resultSplit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge computer_reset) begin
        if (computer_reset) r_state <= IDLE;
        else                r_state <= w_nextState;
    end

    // Next-state decode plus single-cycle event strobes for the datapath.
    // In ARM a still-high all_done after settling is treated as stale and
    // holds off evaluation, bounded by the timeout counter. In EVAL done
    // wins over a coincident timeout.
    always_comb begin
        w_nextState  = r_state;
        w_accept     = 1'b0;
        w_armToEval  = 1'b0;
        w_capture    = 1'b0;
        w_timeoutHit = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_accept    = 1'b1;
                    w_nextState = ARM;
                end
            end
            ARM: begin
                if (w_settled) begin
                    if (!bus.puf_all_done) begin
                        w_armToEval = 1'b1;
                        w_nextState = EVAL;
                    end else if (w_toLast) begin
                        w_timeoutHit = 1'b1;
                        w_nextState  = RESP;
                    end
                end
            end
            EVAL: begin
                if (bus.puf_all_done) begin
                    w_capture   = 1'b1;
                    w_nextState = w_lastPass ? RESP : ARM;
                end else if (w_toLast) begin
                    w_timeoutHit = 1'b1;
                    w_nextState  = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Datapath: challenge capture, settle/timeout counters, vote index and
    // the registered response. Counters restart on every entry to ARM and
    // the timeout counter restarts again on entry to EVAL, so a stale-done
    // extension never eats into the evaluation window.
    always_ff @(posedge clk or posedge computer_reset) begin
        if (computer_reset) begin
            r_challenge <= '0;
            r_settleCnt <= '0;
            r_toCnt     <= '0;
            r_voteIdx   <= '0;
            r_response  <= '0;
            r_timeout   <= 1'b0;
            r_unstable  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_challenge <= bus.req_challenge;
                        r_settleCnt <= '0;
                        r_toCnt     <= '0;
                        r_voteIdx   <= '0;
                        r_timeout   <= 1'b0;
                        r_unstable  <= 1'b0;
                    end
                end
                ARM: begin
                    if (!w_settled) r_settleCnt <= r_settleCnt + 8'd1;
                    if (w_armToEval)
                        r_toCnt <= '0;
                    else if (w_settled && bus.puf_all_done)
                        r_toCnt <= r_toCnt + 16'd1;
                    if (w_timeoutHit) begin
                        r_response <= '0;
                        r_timeout  <= 1'b1;
                        r_unstable <= 1'b0;
                    end
                end
                EVAL: begin
                    r_toCnt <= r_toCnt + 16'd1;
                    if (w_capture) begin
                        if (w_lastPass) begin
                            r_response <= w_result;
                            r_unstable <= w_resultSplit;
                        end else begin
                            r_voteIdx   <= r_voteIdx + 2'd1;
                            r_settleCnt <= '0;
                            r_toCnt     <= '0;
                        end
                    end else if (w_timeoutHit) begin
                        r_response <= '0;
                        r_timeout  <= 1'b1;
                        r_unstable <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready     = (r_state == IDLE);
    assign bus.rsp_valid     = (r_state == RESP);
    assign bus.rsp_response  = r_response;
    assign bus.rsp_timeout   = r_timeout;
    assign bus.rsp_unstable  = r_unstable;
    assign bus.puf_enable    = (r_state == EVAL);
    assign bus.puf_challenge = r_challenge;
    assign busy              = (r_state != IDLE);

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// ---------------------------------------------------------------------------
// tb_puf_challenge_sequencer
// Drives the sequencer with directed and random requests while a small
// behavioural PUF array answers enable pulses. Expected responses, flags and
// cycle counts come from a request-level model of the settle/evaluate rules.
// Honours PUF_MAJORITY_VOTE_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_puf_challenge_sequencer;
    import puf_ctrl_pkg::*;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 10;
    localparam int LIMIT   = 400;
`ifdef PUF_MAJORITY_VOTE_EN
    localparam int PASSES = 3;
`else
    localparam int PASSES = 1;
`endif

    logic clk;
    logic rst;
    logic busy;
    int   testsRun;
    int   testsFailed;

    puf_challenge_sequencer_if bus ();

    puf_challenge_sequencer #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk            (clk),
        .computer_reset (rst),
        .bus            (bus),
        .busy           (busy)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bitwise majority over the samples of n passes (n is 1 or 3)
    function automatic logic [7:0] vote_word(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c, input int n);
        logic [7:0] w;
        int ones;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            ones = int'(a[k]);
            if (n > 1) ones = ones + int'(b[k]) + int'(c[k]);
            w[k] = (2 * ones > n);
        end
        return w;
    endfunction

    // True when some bit differs between the samples of n passes
    function automatic logic vote_split(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c, input int n);
        logic s;
        int ones;
        s = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ones = int'(a[k]);
            if (n > 1) ones = ones + int'(b[k]) + int'(c[k]);
            if (ones != 0 && ones != n) s = 1'b1;
        end
        return s;
    endfunction

    // One full request. doneAt = enable cycle (1-based, every pass) on which
    // the array reports done, 0 = never. stale = extra cycles all_done stays
    // high past the settle window in the first pass. holdCycles = cycles the
    // consumer stalls the response while a competing request is presented.
    task automatic run_request(input string name, input logic [7:0] ch, input int doneAt,
                               input int stale, input logic [7:0] o0, input logic [7:0] o1,
                               input logic [7:0] o2, input int holdCycles);
        logic [7:0] outs [3];
        logic       expTo;
        int         armFirst, expEn, expRsp;
        logic [7:0] expResp;
        logic       expUnst;
        int         cyc, enCount, evalCnt, passIdx, rspCycle, chBad, busyBad, holdBad;
        logic       doneGiven, seenRsp;
        logic [7:0] r0;
        logic       t0, u0;

        outs[0] = o0; outs[1] = o1; outs[2] = o2;

        expTo    = (doneAt == 0);
        armFirst = (stale == 0) ? SETTLE : SETTLE + stale + 1;
        if (expTo) begin
            expEn   = TIMEOUT;
            expRsp  = armFirst + TIMEOUT + 1;
            expResp = 8'h00;
            expUnst = 1'b0;
        end else begin
            expEn   = PASSES * doneAt;
            expRsp  = armFirst + doneAt + (PASSES - 1) * (SETTLE + doneAt) + 1;
            expResp = vote_word(o0, o1, o2, PASSES);
            expUnst = vote_split(o0, o1, o2, PASSES);
        end

        @(negedge clk);
        testsRun++;
        if (bus.req_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL %s idle_ready: got %b expected 1", name, bus.req_ready);
        end
        bus.req_valid     = 1'b1;
        bus.req_challenge = ch;
        bus.rsp_ready     = 1'b0;
        bus.puf_all_done  = 1'b0;
        @(posedge clk);

        cyc = 1; enCount = 0; evalCnt = 0; passIdx = 0; rspCycle = 0;
        chBad = 0; busyBad = 0; doneGiven = 1'b0; seenRsp = 1'b0;
        while (!seenRsp && cyc < LIMIT) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (bus.rsp_valid === 1'b1) begin
                seenRsp  = 1'b1;
                rspCycle = cyc;
            end else begin
                if (doneGiven) begin
                    passIdx++;
                    evalCnt   = 0;
                    doneGiven = 1'b0;
                end
                if (busy !== 1'b1 || bus.req_ready !== 1'b0) busyBad++;
                if (bus.puf_enable === 1'b1) begin
                    enCount++;
                    evalCnt++;
                    if (bus.puf_challenge !== ch) chBad++;
                    if (evalCnt == doneAt) begin
                        bus.puf_all_done = 1'b1;
                        bus.puf_out      = (passIdx < 3) ? outs[passIdx] : 8'h00;
                        doneGiven        = 1'b1;
                    end else begin
                        bus.puf_all_done = 1'b0;
                        bus.puf_out      = 8'($urandom);
                    end
                end else begin
                    bus.puf_all_done = (passIdx == 0 && stale > 0 && cyc <= SETTLE + stale);
                    bus.puf_out      = 8'($urandom);
                end
                cyc++;
            end
        end

        testsRun++;
        if (!seenRsp) begin
            testsFailed++;
            $display("[TB] FAIL %s rsp_wait: no rsp_valid within %0d cycles", name, LIMIT);
            bus.puf_all_done = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            return;
        end

        bus.puf_all_done = 1'b0;
        testsRun++;
        if (rspCycle != expRsp) begin
            testsFailed++;
            $display("[TB] FAIL %s rsp_latency: got %0d expected %0d", name, rspCycle, expRsp);
        end
        testsRun++;
        if (enCount != expEn) begin
            testsFailed++;
            $display("[TB] FAIL %s enable_cycles: got %0d expected %0d", name, enCount, expEn);
        end
        testsRun++;
        if (bus.rsp_response !== expResp) begin
            testsFailed++;
            $display("[TB] FAIL %s response: got %h expected %h", name, bus.rsp_response, expResp);
        end
        testsRun++;
        if (bus.rsp_timeout !== expTo) begin
            testsFailed++;
            $display("[TB] FAIL %s timeout_flag: got %b expected %b", name, bus.rsp_timeout, expTo);
        end
        testsRun++;
        if (bus.rsp_unstable !== expUnst) begin
            testsFailed++;
            $display("[TB] FAIL %s unstable_flag: got %b expected %b", name, bus.rsp_unstable, expUnst);
        end
        testsRun++;
        if (chBad != 0) begin
            testsFailed++;
            $display("[TB] FAIL %s challenge_hold: got %0d bad cycles expected 0", name, chBad);
        end
        testsRun++;
        if (busyBad != 0) begin
            testsFailed++;
            $display("[TB] FAIL %s busy_ready: got %0d bad cycles expected 0", name, busyBad);
        end

        r0 = bus.rsp_response; t0 = bus.rsp_timeout; u0 = bus.rsp_unstable;
        holdBad = 0;
        if (holdCycles > 0) begin
            bus.req_valid     = 1'b1;
            bus.req_challenge = ~ch;
            for (int i = 0; i < holdCycles; i++) begin
                @(negedge clk);
                if (bus.rsp_valid !== 1'b1 || bus.rsp_response !== r0 ||
                    bus.rsp_timeout !== t0 || bus.rsp_unstable !== u0 ||
                    bus.req_ready !== 1'b0 || busy !== 1'b1) holdBad++;
            end
            testsRun++;
            if (holdBad != 0) begin
                testsFailed++;
                $display("[TB] FAIL %s rsp_hold: got %0d unstable cycles expected 0", name, holdBad);
            end
        end

        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        testsRun++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL %s back_to_idle: got valid=%b ready=%b busy=%b expected 0/1/0",
                     name, bus.rsp_valid, bus.req_ready, busy);
        end
        testsRun++;
        if (bus.puf_challenge !== ch) begin
            testsFailed++;
            $display("[TB] FAIL %s idle_challenge: got %h expected %h", name, bus.puf_challenge, ch);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        testsRun++;
        if (bus.req_ready !== 1'b1 || busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset handshake: got ready=%b busy=%b valid=%b expected 1/0/0",
                     bus.req_ready, busy, bus.rsp_valid);
        end
        testsRun++;
        if (bus.rsp_response !== 8'h00 || bus.rsp_timeout !== 1'b0 || bus.rsp_unstable !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset response: got %h/%b/%b expected 00/0/0",
                     bus.rsp_response, bus.rsp_timeout, bus.rsp_unstable);
        end
        testsRun++;
        if (bus.puf_enable !== 1'b0 || bus.puf_challenge !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL reset array: got en=%b ch=%h expected 0/00",
                     bus.puf_enable, bus.puf_challenge);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        run_request("single", 8'hA5, 3, 0, 8'h3C, 8'h3C, 8'h3C, 0);
    endtask

    task automatic test_timeout();
        run_request("timeout", 8'h5E, 0, 0, 8'hFF, 8'hFF, 8'hFF, 0);
    endtask

    task automatic test_done_at_limit();
        run_request("done_at_limit", 8'h17, TIMEOUT, 0, 8'hC9, 8'hC9, 8'hC9, 0);
    endtask

    task automatic test_stale_done();
        run_request("stale_done", 8'h42, 2, 6, 8'h81, 8'h81, 8'h81, 0);
    endtask

    task automatic test_back_to_back();
        run_request("backpressure", 8'h99, 4, 0, 8'h6E, 8'h6E, 8'h6E, 20);
        run_request("back_to_back", 8'h0F, 1, 0, 8'hD2, 8'hD2, 8'hD2, 0);
    endtask

`ifdef PUF_MAJORITY_VOTE_EN
    task automatic test_vote();
        run_request("vote_split", 8'h3A, 2, 0, 8'hF0, 8'hF1, 8'h70, 0);
        run_request("vote_same", 8'hB4, 3, 0, 8'h5A, 8'h5A, 8'h5A, 0);
    endtask
`endif

    task automatic test_reset_mid_eval();
        int waited;
        @(negedge clk);
        bus.req_valid     = 1'b1;
        bus.req_challenge = 8'hC3;
        bus.puf_all_done  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        waited = 0;
        while (bus.puf_enable !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        testsRun++;
        if (waited >= 50) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid reach_eval: got enable=%b expected 1", bus.puf_enable);
        end
        #2 rst = 1'b1;
        #1;
        testsRun++;
        if (bus.puf_enable !== 1'b0 || busy !== 1'b0 || bus.req_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid outputs: got en=%b busy=%b ready=%b expected 0/0/1",
                     bus.puf_enable, busy, bus.req_ready);
        end
        testsRun++;
        if (bus.puf_challenge !== 8'h00 || bus.rsp_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid state: got ch=%h valid=%b expected 00/0",
                     bus.puf_challenge, bus.rsp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        run_request("after_reset", 8'h6B, 2, 0, 8'h24, 8'h24, 8'h24, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            run_request("random", 8'($urandom), int'($urandom_range(0, TIMEOUT)),
                        ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0,
                        8'($urandom), 8'($urandom), 8'($urandom),
                        int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        testsRun          = 0;
        testsFailed       = 0;
        rst               = 1'b1;
        bus.req_valid     = 1'b0;
        bus.req_challenge = 8'h00;
        bus.rsp_ready     = 1'b0;
        bus.puf_out       = 8'h00;
        bus.puf_all_done  = 1'b0;

        test_reset();
        test_single();
        test_timeout();
        test_done_at_limit();
        test_stale_done();
        test_back_to_back();
`ifdef PUF_MAJORITY_VOTE_EN
        test_vote();
`endif
        test_reset_mid_eval();
        test_random();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/puf_challenge_sequencer.md
# puf_challenge_sequencer

Controller that sits between the host-side request interface and the 8-bit parallel PUF array (`puf_parallel`). It accepts one challenge at a time over a valid/ready handshake and drives the array's `enable` and `challenge` inputs through a settle/evaluate sequence. It waits for the array's `all_done` under a cycle timeout, then returns the captured response over a second valid/ready handshake. With voting compiled in, each challenge is evaluated three times and the response is the bitwise majority.

## Interface
- `SETTLE_CYCLES`, default 4: cycles `puf_enable` is held low with the new challenge applied before evaluation (range 1–255).
- `TIMEOUT_CYCLES`, default 255: maximum EVAL cycles waiting for `puf_all_done` (range 2–65535).
- `clk`  in  1  single clock.
- `computer_reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  challenge request valid.
- `req_ready`  out  1  sequencer can accept a challenge.
- `req_challenge`  in  8  challenge word.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_response`  out  8  PUF response (voted if enabled).
- `rsp_timeout`  out  1  evaluation timed out; `rsp_response` = 8'h00.
- `rsp_unstable`  out  1  vote disagreement on at least one bit (0 when voting not compiled).
- `puf_enable`  out  1  to array `enable`.
- `puf_challenge`  out  8  to array `challenge`.
- `puf_out`  in  8  from array `out`.
- `puf_all_done`  in  1  from array `all_done`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE: `req_ready`=1. Accept on `req_valid`&`req_ready`, register the challenge, clear the vote index, go to ARM.
  - ARM: `puf_enable`=0, `puf_challenge` = registered challenge, settle counter runs. Leave for EVAL only when the counter reaches `SETTLE_CYCLES` AND `puf_all_done`=0.
    - If `all_done` stays high (stale), ARM extends. The timeout counter runs during the extension; reaching `TIMEOUT_CYCLES` in ARM goes to RESP with timeout.
  - EVAL: `puf_enable`=1, timeout counter increments each cycle.
    - `puf_all_done` sampled high: capture `puf_out` into the sample slot for the current vote index.
    - Then go to RESP, or to ARM for the next vote.
    - Counter reaching `TIMEOUT_CYCLES`-1 without done: go to RESP with `rsp_timeout`=1, response 0. Remaining votes are abandoned.
  - RESP: `rsp_valid`=1 with registered data held stable until `rsp_ready`. On handshake go to IDLE.
- `rsp_valid` must not depend combinationally on `rsp_ready`.
- `req_ready` is low in all states but IDLE. No request is accepted in the handshake cycle of RESP.
- `puf_challenge` holds its last value in IDLE. Reset value is 8'h00.
- Challenge is never changed while `puf_enable`=1.
- Reset mid-operation: all outputs return to reset values immediately. Captured samples are discarded; any in-flight request is lost.
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_response`=0, `rsp_timeout`=0, `rsp_unstable`=0, `puf_enable`=0, `puf_challenge`=0, `busy`=0, state=IDLE.

## Timing
- Accept at cycle 0. ARM occupies cycles 1..`SETTLE_CYCLES`. First EVAL cycle is `SETTLE_CYCLES`+1.
- Done sampled in EVAL at cycle t gives `rsp_valid` at t+1 (single vote).
- Timeout with `TIMEOUT_CYCLES`=N: EVAL lasts exactly N cycles, and `rsp_valid` rises the cycle after the last one.
- Counters are 8-bit (settle) and 16-bit (timeout). Both clear on every ARM entry.
- Done arriving in the same cycle the timeout limit is reached counts as success: done has priority.

## Configuration
- `PUF_MAJORITY_VOTE_EN` defined:
  - Three ARM→EVAL passes per request with the same challenge.
  - `rsp_response` = bitwise majority of the three samples.
  - `rsp_unstable` = OR over bits of (samples not all equal).
  - Latency is approximately three times that of a single vote.
- Not defined: single pass, `rsp_unstable` tied 0, sample storage reduced to one register.

## Structure
- Shared package `puf_ctrl_pkg`:
  - state enum (IDLE, ARM, EVAL, RESP);
  - `PUF_CW`=8, `PUF_RW`=8;
  - vote count constant (3).
- One combinational sub-module, `puf_majority3`: three 8-bit inputs, outputs majority and disagreement flag. Instantiated only under `PUF_MAJORITY_VOTE_EN`.

## Test plan
- Single request 8'hA5, SETTLE=4, model asserts done 3 cycles into EVAL with `out`=8'h3C → `puf_enable` high for exactly 3 cycles, then `rsp_valid`, `rsp_response`=8'h3C, `rsp_timeout`=0.
- Done never asserted, TIMEOUT=10 → `puf_enable` high exactly 10 cycles, then `rsp_timeout`=1, `rsp_response`=8'h00, then back to IDLE.
- Stale `all_done` held high 6 cycles past settle → EVAL entry delayed until done falls; `puf_enable` stays 0 meanwhile.
- `rsp_ready` held low 20 cycles → `rsp_valid` and data stable; `req_ready`=0; new `req_valid` ignored.
- Vote build, samples 8'hF0, 8'hF1, 8'h70 → `rsp_response`=8'hF0, `rsp_unstable`=1. Identical samples 8'h5A → `rsp_unstable`=0.
- `computer_reset` pulsed during EVAL → same cycle `puf_enable`=0, `busy`=0, `req_ready`=1. The next request completes normally.
